// File: rtl/panda_risc_v_dpc_pkg.sv
// Shared definitions for the data-dependency tracking table.
package panda_risc_v_dpc_pkg;

  localparam int unsigned REG_ID_W = 5;

  typedef enum logic [1:0] {
    DPC_ST_FREE  = 2'b00,
    DPC_ST_DCD   = 2'b01,
    DPC_ST_DSPTC = 2'b10
  } dpc_state_e;

  typedef struct packed {
    dpc_state_e          state;
    logic [REG_ID_W-1:0] rd_id;
    logic                rd_vld;
  } dpc_entry_t;

  localparam dpc_entry_t DPC_ENTRY_RST = '{state: DPC_ST_FREE, rd_id: '0, rd_vld: 1'b0};

endpackage

// File: rtl/panda_risc_v_dpc_entry_match.sv
// Per-entry hazard match: flags whether one table entry's pending RD write
// collides with the RS1/RS2/RD query indices of the querying instruction.
module panda_risc_v_dpc_entry_match
  import panda_risc_v_dpc_pkg::*;
#(
  parameter int unsigned inst_id_width = 4
) (
  input  logic [1:0]               state_i,
  input  logic [REG_ID_W-1:0]      rd_id_i,
  input  logic                     rd_vld_i,
  input  logic [inst_id_width-1:0] entry_idx_i,
  input  logic [inst_id_width-1:0] self_id_i,
  input  logic [REG_ID_W-1:0]      rs1_id_i,
  input  logic [REG_ID_W-1:0]      rs2_id_i,
  input  logic [REG_ID_W-1:0]      rd_q_id_i,
  output logic                     rs1_match_o,
  output logic                     rs2_match_o,
  output logic                     rd_match_o
);

  logic live;

  // The querying instruction never conflicts with its own entry
  assign live = (state_i != 2'(DPC_ST_FREE)) & rd_vld_i & (entry_idx_i != self_id_i);

  assign rs1_match_o = live & (rd_id_i == rs1_id_i)  & (rs1_id_i  != '0);
  assign rs2_match_o = live & (rd_id_i == rs2_id_i)  & (rs2_id_i  != '0);
  assign rd_match_o  = live & (rd_id_i == rd_q_id_i) & (rd_q_id_i != '0);

endmodule

// File: rtl/panda_risc_v_dpc_tracker.sv
// Data-dependency tracking table indexed by instruction ID; answers RAW/WAW queries.
// Optional macro PANDA_RISC_V_DPC_RETIRE_BYPASS_EN masks retiring entries from queries.
module panda_risc_v_dpc_tracker
  import panda_risc_v_dpc_pkg::*;
#(
  parameter int unsigned inst_id_width    = 4,
  parameter int unsigned simulation_delay = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sys_reset_req,
  input  logic                     flush_req,
  input  logic [inst_id_width-1:0] dpc_trace_dcd_inst_id,
  input  logic [REG_ID_W-1:0]      dpc_trace_dcd_rd_id,
  input  logic                     dpc_trace_dcd_rd_vld,
  input  logic                     dpc_trace_dcd_valid,
  input  logic [inst_id_width-1:0] dpc_trace_dsptc_inst_id,
  input  logic                     dpc_trace_dsptc_valid,
  input  logic [inst_id_width-1:0] dpc_trace_retire_inst_id,
  input  logic                     dpc_trace_retire_valid,
  input  logic [inst_id_width-1:0] dpc_check_self_inst_id,
  input  logic [REG_ID_W-1:0]      raw_dpc_check_rs1_id,
  output logic                     rs1_raw_dpc,
  input  logic [REG_ID_W-1:0]      raw_dpc_check_rs2_id,
  output logic                     rs2_raw_dpc,
  input  logic [REG_ID_W-1:0]      waw_dpc_check_rd_id,
  output logic                     rd_waw_dpc,
  output logic [inst_id_width:0]   dpc_tracker_cnt,
  output logic                     dpc_tracker_full,
  output logic                     dpc_tracker_empty
);

  localparam int unsigned DEPTH = 1 << inst_id_width;
  localparam int unsigned CNT_W = inst_id_width + 1;

  dpc_entry_t       tbl_q [DEPTH];
  dpc_entry_t       tbl_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             clr, dcd_retire_same, alloc, free_ev;
  logic             dcd_bad, dsp_bad;

  assign clr             = sys_reset_req | flush_req;
  assign dcd_retire_same = dpc_trace_dcd_valid & dpc_trace_retire_valid &
                           (dpc_trace_dcd_inst_id == dpc_trace_retire_inst_id);
  assign alloc   = dpc_trace_dcd_valid & (tbl_q[dpc_trace_dcd_inst_id].state == DPC_ST_FREE);
  // A same-ID decode re-allocates the retiring entry, so it is not a net free
  assign free_ev = dpc_trace_retire_valid & ~dcd_retire_same &
                   (tbl_q[dpc_trace_retire_inst_id].state != DPC_ST_FREE);

  // Next table state: clear > decode > retire > dispatch
  always_comb begin
    for (int unsigned e = 0; e < DEPTH; e++) begin
      tbl_d[e] = tbl_q[e];
      if (clr) begin
        tbl_d[e] = DPC_ENTRY_RST;
      end else if (dpc_trace_dcd_valid && dpc_trace_dcd_inst_id == inst_id_width'(e)) begin
        tbl_d[e].state  = DPC_ST_DCD;
        tbl_d[e].rd_id  = dpc_trace_dcd_rd_id;
        tbl_d[e].rd_vld = dpc_trace_dcd_rd_vld & (dpc_trace_dcd_rd_id != '0);
      end else if (dpc_trace_retire_valid && dpc_trace_retire_inst_id == inst_id_width'(e)) begin
        tbl_d[e].state = DPC_ST_FREE;
      end else if (dpc_trace_dsptc_valid && dpc_trace_dsptc_inst_id == inst_id_width'(e) &&
                   tbl_q[e].state == DPC_ST_DCD) begin
        tbl_d[e].state = DPC_ST_DSPTC;
      end
    end
    cnt_d   = clr ? '0 : cnt_q + CNT_W'(alloc) - CNT_W'(free_ev);
    full_d  = (cnt_d == CNT_W'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned e = 0; e < DEPTH; e++) tbl_q[e] <= DPC_ENTRY_RST;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      for (int unsigned e = 0; e < DEPTH; e++) tbl_q[e] <= tbl_d[e];
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign dpc_tracker_cnt   = cnt_q;
  assign dpc_tracker_full  = full_q;
  assign dpc_tracker_empty = empty_q;

  logic [DEPTH-1:0] rs1_hit, rs2_hit, rd_hit, ret_mask;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
`ifdef PANDA_RISC_V_DPC_RETIRE_BYPASS_EN
    assign ret_mask[g] = dpc_trace_retire_valid &
                         (dpc_trace_retire_inst_id == inst_id_width'(g));
`else
    assign ret_mask[g] = 1'b0;
`endif
    panda_risc_v_dpc_entry_match #(.inst_id_width(inst_id_width)) u_match (
      .state_i     (tbl_q[g].state),
      .rd_id_i     (tbl_q[g].rd_id),
      .rd_vld_i    (tbl_q[g].rd_vld & ~ret_mask[g]),
      .entry_idx_i (inst_id_width'(g)),
      .self_id_i   (dpc_check_self_inst_id),
      .rs1_id_i    (raw_dpc_check_rs1_id),
      .rs2_id_i    (raw_dpc_check_rs2_id),
      .rd_q_id_i   (waw_dpc_check_rd_id),
      .rs1_match_o (rs1_hit[g]),
      .rs2_match_o (rs2_hit[g]),
      .rd_match_o  (rd_hit[g])
    );
  end

  assign rs1_raw_dpc = |rs1_hit;
  assign rs2_raw_dpc = |rs2_hit;
  assign rd_waw_dpc  = |rd_hit;

  // Protocol misuse by the decoder/dispatcher
  assign dcd_bad = dpc_trace_dcd_valid & ~clr & ~dcd_retire_same &
                   (tbl_q[dpc_trace_dcd_inst_id].state != DPC_ST_FREE);
  assign dsp_bad = dpc_trace_dsptc_valid & ~clr &
                   (tbl_q[dpc_trace_dsptc_inst_id].state != DPC_ST_DCD);

  assert property (@(posedge clk) disable iff (rst) !dcd_bad)
    else $error("dpc_tracker: decode into occupied entry %0d (delay param %0d)",
                dpc_trace_dcd_inst_id, simulation_delay);
  assert property (@(posedge clk) disable iff (rst) !dsp_bad)
    else $error("dpc_tracker: dispatch of non-decoded entry %0d",
                dpc_trace_dsptc_inst_id);

endmodule

// File: tb/tb_panda_risc_v_dpc_tracker.sv
// Randomized bench for panda_risc_v_dpc_tracker against an occupancy-table reference model.
module tb_panda_risc_v_dpc_tracker;

  localparam int unsigned W = 4;
  localparam int unsigned N = 16;
`ifdef PANDA_RISC_V_DPC_RETIRE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         sys_reset_req, flush_req;
  logic [W-1:0] dcd_id, dsp_id, ret_id, self_id;
  logic [4:0]   dcd_rd, rs1, rs2, rdq;
  logic         dcd_rdv, dcd_v, dsp_v, ret_v;
  logic         rs1_raw_dpc, rs2_raw_dpc, rd_waw_dpc;
  logic [W:0]   cnt;
  logic         full, empty;

  // Reference: 0 = free, 1 = decoded, 2 = dispatched
  int m_st [N];
  int m_rd [N];
  bit m_vld [N];
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  panda_risc_v_dpc_tracker #(.inst_id_width(W), .simulation_delay(1)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .sys_reset_req            (sys_reset_req),
    .flush_req                (flush_req),
    .dpc_trace_dcd_inst_id    (dcd_id),
    .dpc_trace_dcd_rd_id      (dcd_rd),
    .dpc_trace_dcd_rd_vld     (dcd_rdv),
    .dpc_trace_dcd_valid      (dcd_v),
    .dpc_trace_dsptc_inst_id  (dsp_id),
    .dpc_trace_dsptc_valid    (dsp_v),
    .dpc_trace_retire_inst_id (ret_id),
    .dpc_trace_retire_valid   (ret_v),
    .dpc_check_self_inst_id   (self_id),
    .raw_dpc_check_rs1_id     (rs1),
    .rs1_raw_dpc              (rs1_raw_dpc),
    .raw_dpc_check_rs2_id     (rs2),
    .rs2_raw_dpc              (rs2_raw_dpc),
    .waw_dpc_check_rd_id      (rdq),
    .rd_waw_dpc               (rd_waw_dpc),
    .dpc_tracker_cnt          (cnt),
    .dpc_tracker_full         (full),
    .dpc_tracker_empty        (empty)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int m_hit(input int x);
    if (x == 0) return 0;
    for (int e = 0; e < N; e++) begin
      if (m_st[e] != 0 && m_vld[e] && m_rd[e] == x && e != int'(self_id) &&
          !(BYP && ret_v && int'(ret_id) == e))
        return 1;
    end
    return 0;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int e = 0; e < N; e++) if (m_st[e] != 0) c++;
    return c;
  endfunction

  // Apply this cycle's events in the order dispatch, retire, decode (decode wins)
  task automatic m_update();
    if (rst || sys_reset_req || flush_req) begin
      for (int e = 0; e < N; e++) begin
        m_st[e] = 0; m_rd[e] = 0; m_vld[e] = 1'b0;
      end
    end else begin
      if (dsp_v && m_st[dsp_id] == 1) m_st[dsp_id] = 2;
      if (ret_v) m_st[ret_id] = 0;
      if (dcd_v) begin
        m_st[dcd_id]  = 1;
        m_rd[dcd_id]  = int'(dcd_rd);
        m_vld[dcd_id] = dcd_rdv && dcd_rd != 5'd0;
      end
    end
  endtask

  task automatic idle();
    sys_reset_req = 1'b0; flush_req = 1'b0;
    dcd_v = 1'b0; dcd_id = '0; dcd_rd = '0; dcd_rdv = 1'b0;
    dsp_v = 1'b0; dsp_id = '0; ret_v = 1'b0; ret_id = '0;
    self_id = '0; rs1 = '0; rs2 = '0; rdq = '0;
  endtask

  // Inputs are set at the falling edge; check, then let the rising edge commit them
  task automatic run_cycle();
    #1;
    check_eq("rs1_raw", int'(rs1_raw_dpc), m_hit(int'(rs1)));
    check_eq("rs2_raw", int'(rs2_raw_dpc), m_hit(int'(rs2)));
    check_eq("rd_waw",  int'(rd_waw_dpc),  m_hit(int'(rdq)));
    check_eq("cnt",     int'(cnt),         m_cnt());
    check_eq("full",    int'(full),        int'(m_cnt() == N));
    check_eq("empty",   int'(empty),       int'(m_cnt() == 0));
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic do_flush();
    idle(); flush_req = 1'b1; run_cycle();
  endtask

  initial begin
    for (int e = 0; e < N; e++) begin
      m_st[e] = 0; m_rd[e] = 0; m_vld[e] = 1'b0;
    end
    rst = 1'b1;
    idle();
    rs1 = 5'd5; rs2 = 5'd6; rdq = 5'd7;
    @(negedge clk);
    #1;
    check_eq("rst_rs1", int'(rs1_raw_dpc), 0);
    check_eq("rst_rd", int'(rd_waw_dpc), 0);
    check_eq("rst_cnt", int'(cnt), 0);
    check_eq("rst_empty", int'(empty), 1);
    check_eq("rst_full", int'(full), 0);
    run_cycle();
    rst = 1'b0;
    run_cycle();

    // RAW hit visible to others, hidden from the owning instruction
    idle(); dcd_v = 1'b1; dcd_id = 4'd3; dcd_rd = 5'd5; dcd_rdv = 1'b1; run_cycle();
    idle(); self_id = 4'd4; rs1 = 5'd5; #1;
    check_eq("tp_rs1_other", int'(rs1_raw_dpc), 1);
    run_cycle();
    idle(); self_id = 4'd3; rs1 = 5'd5; #1;
    check_eq("tp_rs1_self", int'(rs1_raw_dpc), 0);
    run_cycle();
    do_flush();

    // x0 never produces a hazard
    idle(); dcd_v = 1'b1; dcd_id = 4'd1; dcd_rd = 5'd0; dcd_rdv = 1'b1; run_cycle();
    idle(); self_id = 4'd9; rdq = 5'd0; #1;
    check_eq("tp_x0_waw", int'(rd_waw_dpc), 0);
    check_eq("tp_x0_cnt", int'(cnt), 1);
    run_cycle();
    do_flush();

    // Retire cycle: hazard persists without bypass, masked with it
    idle(); dcd_v = 1'b1; dcd_id = 4'd2; dcd_rd = 5'd9; dcd_rdv = 1'b1; run_cycle();
    idle(); dsp_v = 1'b1; dsp_id = 4'd2; run_cycle();
    idle(); ret_v = 1'b1; ret_id = 4'd2; self_id = 4'd0; rs2 = 5'd9; #1;
    check_eq("tp_retire_cyc", int'(rs2_raw_dpc), BYP ? 0 : 1);
    run_cycle();
    idle(); rs2 = 5'd9; #1;
    check_eq("tp_after_retire", int'(rs2_raw_dpc), 0);
    run_cycle();
    do_flush();

    // Fill the table, then re-allocate ID 0 while it retires
    for (int i = 0; i < N; i++) begin
      idle(); dcd_v = 1'b1; dcd_id = W'(i); dcd_rd = 5'(i + 1); dcd_rdv = 1'b1; run_cycle();
    end
    idle(); #1;
    check_eq("tp_full", int'(full), 1);
    check_eq("tp_full_cnt", int'(cnt), 16);
    run_cycle();
    idle(); dcd_v = 1'b1; dcd_id = 4'd0; dcd_rd = 5'd20; dcd_rdv = 1'b1;
    ret_v = 1'b1; ret_id = 4'd0; run_cycle();
    idle(); self_id = 4'd1; rs1 = 5'd20; #1;
    check_eq("tp_realloc_cnt", int'(cnt), 16);
    check_eq("tp_realloc_full", int'(full), 1);
    check_eq("tp_realloc_hit", int'(rs1_raw_dpc), 1);
    run_cycle();
    do_flush();

    // Flush overrides a same-cycle decode
    for (int i = 0; i < 5; i++) begin
      idle(); dcd_v = 1'b1; dcd_id = W'(i); dcd_rd = 5'(i + 1); dcd_rdv = 1'b1; run_cycle();
    end
    idle(); flush_req = 1'b1; dcd_v = 1'b1; dcd_id = 4'd7; dcd_rd = 5'd8; dcd_rdv = 1'b1;
    run_cycle();
    idle(); self_id = 4'd15; rs1 = 5'd1; rs2 = 5'd2; rdq = 5'd8; #1;
    check_eq("tp_flush_cnt", int'(cnt), 0);
    check_eq("tp_flush_empty", int'(empty), 1);
    check_eq("tp_flush_rs1", int'(rs1_raw_dpc), 0);
    check_eq("tp_flush_rs2", int'(rs2_raw_dpc), 0);
    check_eq("tp_flush_rd", int'(rd_waw_dpc), 0);
    run_cycle();

    // Random legal traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      ret_v   = ($urandom_range(0, 2) == 0);
      ret_id  = W'($urandom_range(0, N - 1));
      dcd_id  = W'($urandom_range(0, N - 1));
      dcd_rd  = 5'($urandom_range(0, 7));
      dcd_rdv = ($urandom_range(0, 3) != 0);
      dcd_v   = ($urandom_range(0, 1) == 1) &&
                (m_st[dcd_id] == 0 || (ret_v && ret_id == dcd_id));
      dsp_id  = W'($urandom_range(0, N - 1));
      dsp_v   = ($urandom_range(0, 1) == 1) && (m_st[dsp_id] == 1);
      flush_req     = ($urandom_range(0, 99) == 0);
      sys_reset_req = ($urandom_range(0, 149) == 0);
      self_id = W'($urandom_range(0, N - 1));
      rs1     = 5'($urandom_range(0, 7));
      rs2     = 5'($urandom_range(0, 7));
      rdq     = 5'($urandom_range(0, 7));
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
